// File: rtl/ldq_pipe_arb.sv
// Single-slot arbiter for the mem-pipe mm0 stage: loadq entries are served round-robin
// and the storeq drain requester takes priority once it has waited STARVE_CYCLES cycles.
module ldq_pipe_arb #(
    parameter int  NUM_REQ       = 8,
    parameter int  STARVE_CYCLES = 16,
    parameter type t_mempipe_arb = logic [31:0]
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] ldq_req_mm0,
    input  t_mempipe_arb       ldq_req_pkt_mm0 [NUM_REQ],
    output logic [NUM_REQ-1:0] ldq_gnt_mm0,
    input  logic               stq_req_mm0,
    input  t_mempipe_arb       stq_req_pkt_mm0,
    output logic               stq_gnt_mm0,
    input  logic               pipe_ready_mm0,
    output logic               pipe_valid_mm0,
    output t_mempipe_arb       pipe_req_pkt_mm0,
    output logic               stq_prio
);

    localparam int             PTR_W      = $clog2(NUM_REQ);
    localparam logic [PTR_W:0] NUM_REQ_W  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [7:0]     STARVE_MAX = 8'(STARVE_CYCLES);

    logic [PTR_W-1:0] rr_ptr;
    logic [7:0]       stq_wait;

    logic             active;
    logic             ld_any;
    logic             prio_raw;
    logic             stq_win;
    logic             ld_win;
    logic             ld_found;
    logic [PTR_W-1:0] ld_sel;
    logic [PTR_W:0]   scan;

    assign active   = ~reset & pipe_ready_mm0;
    assign ld_any   = |ldq_req_mm0;
    assign prio_raw = (stq_wait == STARVE_MAX) & stq_req_mm0;
    assign stq_win  = stq_req_mm0 & (prio_raw | ~ld_any);
    assign stq_prio = prio_raw & ~reset;

    // Scan from rr_ptr upward, wrapping at NUM_REQ (not at a power of two).
    always_comb begin
        ld_found = 1'b0;
        ld_sel   = '0;
        scan     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (scan >= NUM_REQ_W) begin
                scan = scan - NUM_REQ_W;
            end
            if (!ld_found && ldq_req_mm0[scan[PTR_W-1:0]]) begin
                ld_found = 1'b1;
                ld_sel   = scan[PTR_W-1:0];
            end
        end
    end

    assign ld_win = active & ~stq_win & ld_found;

    always_comb begin
        stq_gnt_mm0      = active & stq_win;
        ldq_gnt_mm0      = ld_win ? (NUM_REQ'(1) << ld_sel) : '0;
        pipe_valid_mm0   = stq_gnt_mm0 | ld_win;
        pipe_req_pkt_mm0 = '0;
        if (stq_gnt_mm0) begin
            pipe_req_pkt_mm0 = stq_req_pkt_mm0;
        end else if (ld_win) begin
            pipe_req_pkt_mm0 = ldq_req_pkt_mm0[ld_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            stq_wait <= '0;
        end else begin
            if (ld_win) begin
                rr_ptr <= (ld_sel == LAST_IDX) ? '0 : ld_sel + PTR_W'(1);
            end
            // Keeps counting under backpressure, saturating at the priority threshold.
            if (stq_gnt_mm0 || !stq_req_mm0) begin
                stq_wait <= '0;
            end else if (stq_wait != STARVE_MAX) begin
                stq_wait <= stq_wait + 8'd1;
            end
        end
    end

    a_onehot_gnt : assert property (@(posedge clk) disable iff (reset)
        $onehot0({ldq_gnt_mm0, stq_gnt_mm0}));
    a_gnt_has_req : assert property (@(posedge clk) disable iff (reset)
        ((ldq_gnt_mm0 & ~ldq_req_mm0) == '0) && !(stq_gnt_mm0 && !stq_req_mm0));
    a_no_gnt_not_ready : assert property (@(posedge clk) disable iff (reset)
        !pipe_ready_mm0 |-> !pipe_valid_mm0);
    a_wait_bound : assert property (@(posedge clk) disable iff (reset)
        stq_wait <= STARVE_MAX);

endmodule

// File: tb/tb_ldq_pipe_arb.sv
// Bench for ldq_pipe_arb: two instances (starve thresholds 16 and 4) driven by the same
// directed and random stimulus, compared each cycle against a rule-level arbitration model.
module tb_ldq_pipe_arb;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [N-1:0] ldq_req;
    logic [31:0] ldq_pkt [N];
    logic        stq_req;
    logic [31:0] stq_pkt;
    logic        ready;

    logic [N-1:0] gnt0, gnt1;
    logic        sgnt0, sgnt1, val0, val1, prio0, prio1;
    logic [31:0] pkt0, pkt1;

    int checks   = 0;
    int failures = 0;

    // model state and per-cycle observations (index 0: starve 16, index 1: starve 4)
    int          starve [2] = '{16, 4};
    int          m_rr   [2];
    int          m_wait [2];
    int          e_sel  [2];
    logic        e_stq  [2];
    logic [N-1:0] o_gnt [2];
    logic        o_stq  [2];

    always #5 clk = ~clk;

    ldq_pipe_arb #(.NUM_REQ(N), .STARVE_CYCLES(16)) u_dut0 (
        .clk(clk), .reset(reset),
        .ldq_req_mm0(ldq_req), .ldq_req_pkt_mm0(ldq_pkt), .ldq_gnt_mm0(gnt0),
        .stq_req_mm0(stq_req), .stq_req_pkt_mm0(stq_pkt), .stq_gnt_mm0(sgnt0),
        .pipe_ready_mm0(ready), .pipe_valid_mm0(val0), .pipe_req_pkt_mm0(pkt0),
        .stq_prio(prio0)
    );

    ldq_pipe_arb #(.NUM_REQ(N), .STARVE_CYCLES(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .ldq_req_mm0(ldq_req), .ldq_req_pkt_mm0(ldq_pkt), .ldq_gnt_mm0(gnt1),
        .stq_req_mm0(stq_req), .stq_req_pkt_mm0(stq_pkt), .stq_gnt_mm0(sgnt1),
        .pipe_ready_mm0(ready), .pipe_valid_mm0(val1), .pipe_req_pkt_mm0(pkt1),
        .stq_prio(prio1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: evaluate rules at negedge, compare, then advance model at posedge.
    task automatic cycle();
        logic [N-1:0] eg;
        logic [31:0]  ep;
        logic         ev, eprio;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            e_sel[d] = -1;
            e_stq[d] = 1'b0;
            eprio    = 1'b0;
            if (!reset) begin
                eprio = stq_req && (m_wait[d] == starve[d]);
                if (ready) begin
                    if (stq_req && (eprio || ldq_req == '0)) begin
                        e_stq[d] = 1'b1;
                    end else begin
                        for (int j = 0; j < N; j++) begin
                            if (ldq_req[(m_rr[d] + j) % N]) begin
                                e_sel[d] = (m_rr[d] + j) % N;
                                break;
                            end
                        end
                    end
                end
            end
            eg = '0;
            ep = '0;
            if (e_sel[d] >= 0) begin
                eg[e_sel[d]] = 1'b1;
                ep = ldq_pkt[e_sel[d]];
            end
            if (e_stq[d]) ep = stq_pkt;
            ev = e_stq[d] || (e_sel[d] >= 0);
            o_gnt[d] = (d == 0) ? gnt0 : gnt1;
            o_stq[d] = (d == 0) ? sgnt0 : sgnt1;
            chk($sformatf("gnt%0d", d), 64'(o_gnt[d]), 64'(eg));
            chk($sformatf("stq_gnt%0d", d), 64'(o_stq[d]), 64'(e_stq[d]));
            chk($sformatf("valid%0d", d), 64'((d == 0) ? val0 : val1), 64'(ev));
            chk($sformatf("pkt%0d", d), 64'((d == 0) ? pkt0 : pkt1), 64'(ep));
            chk($sformatf("prio%0d", d), 64'((d == 0) ? prio0 : prio1), 64'(eprio));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_rr[d]   = 0;
                m_wait[d] = 0;
            end else begin
                if (e_sel[d] >= 0) m_rr[d] = (e_sel[d] + 1) % N;
                if (e_stq[d] || !stq_req) m_wait[d] = 0;
                else if (m_wait[d] < starve[d]) m_wait[d] = m_wait[d] + 1;
            end
        end
        #1;
        for (int i = 0; i < N; i++) ldq_pkt[i] = $urandom;
        stq_pkt = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        ldq_req = '0;
        stq_req = 1'b0;
        ready   = 1'b1;
        stq_pkt = 32'h5700_0001;
        for (int i = 0; i < N; i++) ldq_pkt[i] = 32'h1000_0000 + i;
        m_rr   = '{0, 0};
        m_wait = '{0, 0};

        // reset state with live requests
        ldq_req = 8'hFF;
        stq_req = 1'b1;
        cycle();
        chk("rst_gnt", 64'(o_gnt[0]), 64'h0);
        cycle();
        reset   = 1'b0;
        stq_req = 1'b0;

        // round robin 0..7,0
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("rr_seq", 64'(o_gnt[0]), 64'(1) << (i % N));
        end
        cycle();
        chk("rr_ptr_end", 64'(o_gnt[0]), 64'h2);

        // skip and wrap: move rr_ptr to 6, then request entries 0 and 2
        do_reset();
        for (int i = 0; i < 6; i++) cycle();
        ldq_req = 8'b0000_0101;
        cycle();
        chk("wrap_e0", 64'(o_gnt[0]), 64'h1);
        cycle();
        chk("skip_e2", 64'(o_gnt[1]), 64'h4);

        // store starvation, threshold 4 instance
        do_reset();
        ldq_req = 8'hFF;
        stq_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("starve_ld", 64'(o_gnt[1]), 64'(1) << i);
        end
        cycle();
        chk("starve_stq", 64'(o_stq[1]), 64'h1);
        cycle();
        chk("starve_rr_hold", 64'(o_gnt[1]), 64'h10);

        // idle loads: store granted at once
        ldq_req = '0;
        cycle();
        chk("idle_stq", 64'(o_stq[0]), 64'h1);

        // backpressure, then release
        do_reset();
        ldq_req = 8'h10;
        stq_req = 1'b1;
        ready   = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        ready = 1'b1;
        cycle();
        chk("bp_stq_first", 64'(o_stq[0]), 64'h1);
        cycle();
        chk("bp_e4_next", 64'(o_gnt[0]), 64'h10);

        // reset mid-stream
        ldq_req = 8'hFF;
        stq_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        cycle();
        chk("midrst_gnt", 64'(o_gnt[0]), 64'h0);
        reset = 1'b0;
        cycle();
        chk("midrst_first", 64'(o_gnt[0]), 64'h1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 59) == 0);
            ready   = ($urandom_range(0, 9) < 8);
            stq_req = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       ldq_req = '0;
                1:       ldq_req = N'(1) << $urandom_range(0, N - 1);
                default: ldq_req = N'($urandom);
            endcase
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ldq_pipe_arb.md
Name: ldq_pipe_arb

Overview:
- Arbitrates mem-pipe mm0 issue slots between all loadq entries and the storeq drain requester.
- Sits between the loadq entry array and the mem pipe mm0 stage.
- Loads are round-robin among entries. A store that has waited too long gets priority.
- The grant is combinational in the same cycle as the request, because entries advance from REQ_PIPE to PDG_PIPE on the grant edge.

Parameters:
- NUM_REQ, default LDQ_NUM_ENTRIES (8): number of loadq requesters. Any value >= 2; need not be a power of two.
- STARVE_CYCLES, default 16: consecutive ungranted store-request cycles before the store gets priority. Range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ldq_req_mm0  in  NUM_REQ  per-entry pipe request (entry's e_pipe_req_mm0)
- ldq_req_pkt_mm0  in  NUM_REQ x t_mempipe_arb  per-entry request packet
- ldq_gnt_mm0  out  NUM_REQ  one-hot grant to loadq entries
- stq_req_mm0  in  1  storeq pipe request
- stq_req_pkt_mm0  in  t_mempipe_arb  storeq request packet
- stq_gnt_mm0  out  1  storeq grant
- pipe_ready_mm0  in  1  mm0 slot can accept a request this cycle
- pipe_valid_mm0  out  1  a request is issued into mm0 this cycle
- pipe_req_pkt_mm0  out  t_mempipe_arb  issued packet
- stq_prio  out  1  store-priority state (debug/perf)

Behaviour:
- The clock is clk. The reset is reset: synchronous and active-high. All state updates on the rising edge of clk.

State:
- rr_ptr: clog2(NUM_REQ) bits, reset 0.
- stq_wait: 8-bit saturating counter, reset 0.

Grant selection (combinational):
- If reset or ~pipe_ready_mm0: no grant. All gnt = 0, pipe_valid_mm0 = 0, pipe_req_pkt_mm0 = '0.
- ld_any = |ldq_req_mm0.
- stq_prio = (stq_wait == STARVE_CYCLES) & stq_req_mm0.
- Store wins if stq_req_mm0 & (stq_prio | ~ld_any).
- Otherwise, if ld_any, grant the first requesting entry found scanning indices rr_ptr, rr_ptr+1, ... mod NUM_REQ. Wrap is at NUM_REQ, not at a power of two.
- At most one bit of {ldq_gnt_mm0, stq_gnt_mm0} is set in any cycle.
- pipe_valid_mm0 = |ldq_gnt_mm0 | stq_gnt_mm0.
- pipe_req_pkt_mm0 is the packet of the granted requester, and '0 when there is no grant. It is not forced to a particular arb_type; the packet passes through unmodified.

rr_ptr update:
- On a load grant to entry k: rr_ptr <= (k+1 == NUM_REQ) ? 0 : k+1.
- Otherwise it holds. A store grant does not move rr_ptr.

stq_wait update (priority: reset > clear > increment):
- Reset: stq_wait <= 0.
- stq_gnt_mm0 or ~stq_req_mm0: stq_wait <= 0.
- stq_req_mm0 & ~stq_gnt_mm0: stq_wait <= min(stq_wait+1, STARVE_CYCLES). Counts even when ~pipe_ready_mm0.
- Consequence: a continuously requesting store is granted no later than the first pipe_ready cycle after STARVE_CYCLES ungranted cycles.

Boundary conditions:
- Request dropped without a grant (entry nuked or blocked by stq elders): no state change except the stq_wait clear described above.
- pipe_ready_mm0 low for many cycles: rr_ptr holds; stq_wait saturates and does not wrap.
- Reset asserted mid-operation: outputs are zero in that same cycle; state is back to reset values the next cycle.
- Single requester: granted every ready cycle.

Assertions (ASSERT):
- Grant vector is onehot0.
- A grant is only given to an asserted request.
- No grant when ~pipe_ready_mm0.
- stq_wait <= STARVE_CYCLES.

Test Plan:
- Round-robin: after reset, ldq_req=8'hFF held and pipe_ready=1 for 9 cycles -> grants to entries 0,1,2,...,7,0; rr_ptr ends at 1.
- Skip and wrap: rr_ptr=6, ldq_req=8'b0000_0101 -> grant entry 0, rr_ptr=1; next cycle same request -> grant entry 2, rr_ptr=3.
- Store starvation: STARVE_CYCLES=4, ldq_req=8'hFF and stq_req=1 continuously -> stores ungranted for 4 cycles; store granted in cycle 5 with stq_prio=1; stq_wait returns to 0; rr_ptr unchanged during the store grant.
- Idle loads: ldq_req=0, stq_req=1 -> store granted the same cycle; pipe_req_pkt equals stq_req_pkt.
- Backpressure: pipe_ready=0 for 20 cycles with ldq_req=8'h10 and stq_req=1 -> no grants, pipe_valid=0, stq_wait saturates at 16; pipe_ready=1 -> store granted first, entry 4 granted the next cycle.
- Reset mid-stream: assert reset while grants are flowing -> all gnt=0 and pipe_valid=0 in that cycle; after reset drops, rr_ptr=0, so with 8'hFF requested the first grant goes to entry 0.
